// File: rtl/bsync_align_gen.sv
// Measures the period of an asynchronous reference bsync, then regenerates
// phase-offset bsync copies per channel while monitoring reference alignment.
module bsync_align_gen #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int ALIGN_TOL = 1,
    parameter int MAX_MISS  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bsync_in,
    input  logic                    arm,
    input  logic                    recal,
    input  logic                    err_clear,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] ch_offset,
    output logic [NUM_CH-1:0]       bsync_out,
    output logic [CNT_W-1:0]        period,
    output logic [CNT_W-1:0]        last_phase,
    output logic                    ready,
    output logic [3:0]              miss_cnt,
    output logic [1:0]              err_code,
    output logic [NUM_CH-1:0]       offset_err,
    output logic [2:0]              state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_MEAS = 3'd2;
    localparam logic [2:0] S_GEN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;
    localparam int         PW       = CNT_W + 1;
    localparam logic [4:0] MISS_LIM = 5'(MAX_MISS);

    logic              sync1, sync2, sync3, edge_p;
    logic [CNT_W-1:0]  mcnt, phase;
    logic [PW-1:0]     gap;

    logic [2:0]        state_n;
    logic [CNT_W-1:0]  period_n, last_n, mcnt_n, phase_n;
    logic [3:0]        miss_n;
    logic [1:0]        code_n;
    logic [PW-1:0]     gap_n;
    logic [NUM_CH-1:0] out_n;

    // Period arithmetic is one bit wider so 2*P and the modulo never overflow.
    logic [PW-1:0]     p_x, ph_x, half_x, two_p, dev, gap_inc;
    logic [4:0]        miss_inc;
    logic              aligned, gen_keep;

    assign p_x      = {1'b0, period};
    assign ph_x     = {1'b0, phase};
    assign half_x   = p_x >> 1;
    assign two_p    = p_x << 1;
    assign dev      = (ph_x <= half_x) ? ph_x : p_x - ph_x;
    assign aligned  = dev <= PW'(ALIGN_TOL);
    assign gap_inc  = gap + PW'(1);
    assign miss_inc = {1'b0, miss_cnt} + 5'd1;
    assign ready    = (state == S_GEN);
    assign gen_keep = (state == S_GEN) && (state_n == S_GEN);

    always_comb begin
        state_n  = state;
        period_n = period;
        last_n   = last_phase;
        miss_n   = miss_cnt;
        code_n   = err_code;
        mcnt_n   = mcnt;
        phase_n  = phase;
        gap_n    = gap;
        case (state)
            S_IDLE: if (arm) state_n = S_WAIT;
            S_WAIT: if (edge_p) begin
                state_n = S_MEAS;
                mcnt_n  = CNT_W'(1);
            end
            S_MEAS: begin
                if (edge_p) begin
                    period_n = mcnt;
                    phase_n  = '0;
                    gap_n    = '0;
                    if (mcnt < CNT_W'(4)) begin
                        state_n = S_ERR;
                        code_n  = 2'd2;
                    end else begin
                        state_n = S_GEN;
                    end
                end else if (mcnt == '1) begin
                    state_n = S_ERR;
                    code_n  = 2'd1;
                end else begin
                    mcnt_n = mcnt + CNT_W'(1);
                end
            end
            S_GEN: begin
                phase_n = (ph_x + PW'(1) >= p_x) ? '0 : phase + CNT_W'(1);
                if (edge_p) begin
                    last_n = phase;
                    gap_n  = '0;
                    if (aligned) begin
                        miss_n = '0;
                    end else begin
                        miss_n = miss_inc[3:0];
                        if (miss_inc >= MISS_LIM) begin
                            state_n = S_ERR;
                            code_n  = 2'd3;
                        end
                    end
                end else begin
                    gap_n = gap_inc;
                    if (gap_inc >= two_p) begin
                        state_n = S_ERR;
                        code_n  = 2'd3;
                    end
                end
                // An error decided above wins over recal.
                if (recal && state_n == S_GEN) begin
                    state_n = S_WAIT;
                    miss_n  = '0;
                end
            end
            S_ERR: if (err_clear) begin
                state_n = S_IDLE;
                code_n  = '0;
                miss_n  = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [PW-1:0] off_x, diff;
        assign off_x         = {1'b0, ch_offset[i*CNT_W +: CNT_W]};
        assign diff          = (ph_x >= off_x) ? ph_x - off_x : ph_x + p_x - off_x;
        assign offset_err[i] = (state == S_GEN) && (off_x >= p_x);
        assign out_n[i]      = gen_keep && ch_en[i] && (off_x < p_x) && (diff < half_x);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            edge_p     <= 1'b0;
            state      <= S_IDLE;
            period     <= '0;
            last_phase <= '0;
            miss_cnt   <= '0;
            err_code   <= '0;
            mcnt       <= '0;
            phase      <= '0;
            gap        <= '0;
            bsync_out  <= '0;
        end else begin
            sync1      <= bsync_in;
            sync2      <= sync1;
            sync3      <= sync2;
            edge_p     <= sync2 & ~sync3;
            state      <= state_n;
            period     <= period_n;
            last_phase <= last_n;
            miss_cnt   <= miss_n;
            err_code   <= code_n;
            mcnt       <= mcnt_n;
            phase      <= phase_n;
            gap        <= gap_n;
            bsync_out  <= out_n;
        end
    end

endmodule

// File: tb/tb_bsync_align_gen.sv
// Directed bench for bsync_align_gen: acquisition, offsets, alignment misses,
// timeouts, short period, recalibration and reset.
module tb_bsync_align_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst, bsync_in, arm, recal, err_clear;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*CNT_W-1:0] ch_offset;
    logic [NUM_CH-1:0]       bsync_out, offset_err;
    logic [CNT_W-1:0]        period, last_phase;
    logic                    ready;
    logic [3:0]              miss_cnt;
    logic [1:0]              err_code;
    logic [2:0]              state;

    int checks   = 0;
    int failures = 0;

    // Reference generator state: period rp, position rc, extra low cycles hold.
    int rp = 32, rc = 0, hold = 0;
    bit ref_on = 0;

    bsync_align_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ALIGN_TOL(1), .MAX_MISS(3)) dut (
        .clk(clk), .rst(rst), .bsync_in(bsync_in), .arm(arm), .recal(recal),
        .err_clear(err_clear), .ch_en(ch_en), .ch_offset(ch_offset),
        .bsync_out(bsync_out), .period(period), .last_phase(last_phase),
        .ready(ready), .miss_cnt(miss_cnt), .err_code(err_code),
        .offset_err(offset_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        if (hold > 0) hold--;
        else rc = (rc + 1 >= rp) ? 0 : rc + 1;
        bsync_in = ref_on && (rc < rp / 2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int limit);
        for (int i = 0; i < limit && !ready; i++) tick();
        chk(tag, 32'(ready), 32'd1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int limit);
        for (int i = 0; i < limit && state != s; i++) tick();
        chk(tag, 32'(state), 32'(s));
    endtask

    // Delay the next reference rising edge by k cycles (shifts all later edges).
    task automatic shift_edge(input int k);
        for (int i = 0; i < 200 && rc != rp - 1; i++) tick();
        hold = k;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1; tick(); err_clear = 1'b0;
    endtask

    initial begin
        int cnt [NUM_CH];
        int rise [NUM_CH];
        int offs [NUM_CH];
        int k;
        logic [NUM_CH-1:0] prev;

        offs = '{0, 8, 16, 31};
        rst = 1'b1; bsync_in = 1'b0; arm = 1'b0; recal = 1'b0; err_clear = 1'b0;
        ch_en = '1;
        ch_offset = {8'd31, 8'd16, 8'd8, 8'd0};
        ticks(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_out", 32'(bsync_out), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        rst = 1'b0;

        // Acquisition at P=32 and per-channel shape/shift
        ref_on = 1; rp = 32; ticks(40);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_wait", 32'(state), 32'd1);
        wait_ready("acq32_ready", 200);
        chk("acq32_period", 32'(period), 32'd32);
        chk("acq32_state", 32'(state), 32'd3);
        ticks(40);
        chk("acq32_last_phase", 32'(last_phase), 32'd31);
        chk("acq32_miss", 32'(miss_cnt), 32'd0);
        chk("acq32_offerr", 32'(offset_err), 32'd0);
        for (int c = 0; c < NUM_CH; c++) begin cnt[c] = 0; rise[c] = -1; end
        prev = bsync_out;
        for (int t = 0; t < 64; t++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                if (bsync_out[c]) cnt[c]++;
                if (bsync_out[c] && !prev[c] && rise[c] < 0) rise[c] = t;
            end
            prev = bsync_out;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("duty_ch%0d", c), 32'(cnt[c]), 32'd32);
            chk($sformatf("shift_ch%0d", c), 32'(((rise[c] - rise[0]) % 32 + 32) % 32), 32'(offs[c]));
        end

        // Offset beyond the period on channel 0 only
        ch_offset = {8'd31, 8'd16, 8'd8, 8'd40};
        ticks(2);
        chk("offerr_flag", 32'(offset_err), 32'b0001);
        for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
        for (int t = 0; t < 32; t++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) if (bsync_out[c]) cnt[c]++;
        end
        chk("offerr_ch0_low", 32'(cnt[0]), 32'd0);
        chk("offerr_ch1", 32'(cnt[1]), 32'd16);
        chk("offerr_ch3", 32'(cnt[3]), 32'd16);
        ch_offset = {8'd31, 8'd16, 8'd8, 8'd0};
        ticks(2);
        chk("offerr_clear", 32'(offset_err), 32'd0);

        // Alignment: +1 stays aligned, then three +4 shifts -> error 3
        shift_edge(1); ticks(10 + 32);
        chk("shift1_last_phase", 32'(last_phase), 32'd0);
        chk("shift1_miss", 32'(miss_cnt), 32'd0);
        chk("shift1_ready", 32'(ready), 32'd1);
        shift_edge(4); ticks(10);
        chk("shift4a_miss", 32'(miss_cnt), 32'd1);
        chk("shift4a_last_phase", 32'(last_phase), 32'd4);
        shift_edge(4); ticks(10);
        chk("shift4b_miss", 32'(miss_cnt), 32'd2);
        chk("shift4b_last_phase", 32'(last_phase), 32'd8);
        shift_edge(4); ticks(10);
        chk("misalign_state", 32'(state), 32'd4);
        chk("misalign_code", 32'(err_code), 32'd3);
        chk("misalign_out", 32'(bsync_out), 32'd0);
        chk("misalign_ready", 32'(ready), 32'd0);
        recal = 1'b1; arm = 1'b1; tick(); recal = 1'b0; arm = 1'b0;
        chk("err_ignores_arm", 32'(state), 32'd4);

        // err_clear wins over arm
        err_clear = 1'b1; arm = 1'b1; tick(); err_clear = 1'b0; arm = 1'b0;
        chk("clear_prio_state", 32'(state), 32'd0);
        chk("clear_prio_code", 32'(err_code), 32'd0);
        chk("clear_prio_miss", 32'(miss_cnt), 32'd0);

        // Lost reference at P=20
        rp = 20; ticks(50);
        arm = 1'b1; tick(); arm = 1'b0;
        wait_ready("p20_ready", 200);
        chk("p20_period", 32'(period), 32'd20);
        ticks(45);
        k = 0;
        do begin tick(); k++; end while (rc != 0 && k < 100);
        ref_on = 0;
        k = 0;
        for (int i = 0; i < 100 && state != 3'd4; i++) begin tick(); k++; end
        chk("lost_cycles", 32'(k), 32'd44);
        chk("lost_code", 32'(err_code), 32'd3);
        chk("lost_out", 32'(bsync_out), 32'd0);
        pulse_clear();
        chk("lost_clear", 32'(state), 32'd0);

        // Reference period 3 -> too short
        ref_on = 1; rp = 3; ticks(10);
        arm = 1'b1; tick(); arm = 1'b0;
        wait_state("short_state", 3'd4, 50);
        chk("short_code", 32'(err_code), 32'd2);
        chk("short_period", 32'(period), 32'd3);
        pulse_clear();

        // Single edge only -> measurement timeout after 255 cycles
        rp = 32; ticks(40);
        arm = 1'b1; tick(); arm = 1'b0;
        wait_state("meas_enter", 3'd2, 100);
        ref_on = 0;
        k = 0;
        for (int i = 0; i < 400 && state != 3'd4; i++) begin tick(); k++; end
        chk("timeout_cycles", 32'(k), 32'd255);
        chk("timeout_code", 32'(err_code), 32'd1);
        pulse_clear();
        chk("timeout_clear_state", 32'(state), 32'd0);
        chk("timeout_clear_code", 32'(err_code), 32'd0);

        // Recalibrate 32 -> 48
        ref_on = 1; ticks(40);
        arm = 1'b1; tick(); arm = 1'b0;
        wait_ready("recal_ready32", 200);
        chk("recal_period32", 32'(period), 32'd32);
        ticks(20);
        for (int i = 0; i < 200 && rc != rp - 1; i++) tick();
        rp = 48;
        recal = 1'b1; tick(); recal = 1'b0;
        chk("recal_state", 32'(state), 32'd1);
        chk("recal_out", 32'(bsync_out), 32'd0);
        chk("recal_ready_low", 32'(ready), 32'd0);
        chk("recal_hold_period", 32'(period), 32'd32);
        chk("recal_miss", 32'(miss_cnt), 32'd0);
        wait_ready("recal_ready48", 300);
        chk("recal_period48", 32'(period), 32'd48);
        ticks(60);
        chk("p48_running", 32'(bsync_out != '0 || offset_err != '0 || ready), 32'd1);

        // Reset in the middle of GEN
        rst = 1'b1; tick();
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_out", 32'(bsync_out), 32'd0);
        chk("midrst_period", 32'(period), 32'd0);
        chk("midrst_last_phase", 32'(last_phase), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_miss", 32'(miss_cnt), 32'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
